// File: rtl/vga_frame_signature.sv
// Passive VGA sink: measures line timing and frame height, and folds the
// active-region pixels of each frame into a CRC-16-CCITT signature that is
// latched once per frame with a one-cycle FRAME_VALID strobe.
// Optional build macro VGA_SIG_PIXCNT_EN adds PIX_NONZERO, a per-frame count
// of sampled pixels whose RGB value is non-zero.
module vga_frame_signature #(
  parameter int unsigned CLK_PER_PIX = 2,
  parameter int unsigned H_TOTAL     = 1600,
  parameter int unsigned H_START     = 288,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned V_START     = 35,
  parameter int unsigned V_ACTIVE    = 480
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSYNC,
  input  logic        VSYNC,
  input  logic [7:0]  RGB,
  output logic        FRAME_VALID,
  output logic [15:0] FRAME_CRC,
  output logic [11:0] LINE_PERIOD,
  output logic [11:0] HSYNC_WIDTH,
  output logic [10:0] LINE_COUNT,
  output logic        LINE_ERR,
  output logic        FRAME_ERR,
  output logic        LOCKED
`ifdef VGA_SIG_PIXCNT_EN
  ,
  output logic [18:0] PIX_NONZERO
`endif
);

  localparam logic [11:0] h_start  = 12'(H_START);
  localparam logic [11:0] h_end    = 12'(H_START + H_ACTIVE * CLK_PER_PIX);
  localparam logic [11:0] h_total  = 12'(H_TOTAL);
  localparam logic [10:0] v_start  = 11'(V_START);
  localparam logic [10:0] v_end    = 11'(V_START + V_ACTIVE);
  localparam logic [10:0] v_total  = 11'(V_TOTAL);
  localparam logic [1:0]  cpp_last = 2'(CLK_PER_PIX - 1);
  localparam logic [15:0] crc_init = 16'hFFFF;

  typedef enum logic [1:0] {st_idle, st_sync, st_measure} state_e;

  state_e      state_q;
  logic        hsync_q, vsync_q;
  logic        hfall, hrise, vfall;
  logic [11:0] hcnt_q, hcnt_inc;
  logic [11:0] wcnt_q, wcnt_inc;
  logic [10:0] vline_q, vline_inc;
  logic [1:0]  phase_q;
  logic        first_q;
  logic [15:0] crc_q, crc_next;
  logic        in_h, in_v, sample;

  // CRC-16-CCITT (0x1021), one full byte per call, data MSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

  // Edge detection, saturating increments and the pixel-sample decision.
  always_comb begin
    hfall     = hsync_q & ~HSYNC;
    hrise     = ~hsync_q & HSYNC;
    vfall     = vsync_q & ~VSYNC;
    hcnt_inc  = (hcnt_q == 12'hFFF) ? hcnt_q : hcnt_q + 12'd1;
    wcnt_inc  = (wcnt_q == 12'hFFF) ? wcnt_q : wcnt_q + 12'd1;
    vline_inc = (vline_q == 11'h7FF) ? vline_q : vline_q + 11'd1;
    in_h      = (hcnt_q >= h_start) && (hcnt_q < h_end);
    in_v      = (vline_q >= v_start) && (vline_q < v_end);
    sample    = (state_q == st_measure) && in_h && in_v && (phase_q == 2'd0);
    crc_next  = sample ? crc_byte(crc_q, RGB) : crc_q;
  end

  // Sync history and free-running horizontal/vertical/width counters.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      hcnt_q      <= '0;
      wcnt_q      <= '0;
      vline_q     <= '0;
      phase_q     <= '0;
      HSYNC_WIDTH <= '0;
    end else begin
      hsync_q <= HSYNC;
      vsync_q <= VSYNC;
      hcnt_q  <= hfall ? 12'd0 : hcnt_inc;
      // Phase tracks (hcnt - H_START) mod CLK_PER_PIX inside the window.
      if (hfall || (hcnt_q < h_start) || (phase_q == cpp_last)) phase_q <= 2'd0;
      else                                                   phase_q <= phase_q + 2'd1;
      // The fall cycle is the first low cycle, so the width starts at 1.
      if (hfall)       wcnt_q <= 12'd1;
      else if (!HSYNC) wcnt_q <= wcnt_inc;
      if (hrise) HSYNC_WIDTH <= wcnt_q;
      // A VSYNC fall wins over a coincident HSYNC fall.
      if (vfall)      vline_q <= 11'd0;
      else if (hfall) vline_q <= vline_inc;
    end
  end

  // Lock FSM with registered results: line checks and per-frame close.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= st_idle;
      first_q     <= 1'b0;
      crc_q       <= crc_init;
      FRAME_VALID <= 1'b0;
      FRAME_CRC   <= '0;
      LINE_PERIOD <= '0;
      LINE_COUNT  <= '0;
      LINE_ERR    <= 1'b0;
      FRAME_ERR   <= 1'b0;
      LOCKED      <= 1'b0;
    end else begin
      FRAME_VALID <= 1'b0;
      unique case (state_q)
        st_idle: begin
          if (vfall) state_q <= st_sync;
        end
        st_sync: begin
          // Partial first frame is discarded here.
          if (vfall) begin
            state_q <= st_measure;
            LOCKED  <= 1'b1;
            first_q <= 1'b1;
            crc_q   <= crc_init;
          end
        end
        st_measure: begin
          crc_q <= crc_next;
          if (hfall) begin
            LINE_PERIOD <= hcnt_inc;
            // The line in progress at lock may be partial, so skip it.
            if (!first_q && (hcnt_inc != h_total)) LINE_ERR <= 1'b1;
            first_q <= 1'b0;
          end
          if (vfall) begin
            FRAME_VALID <= 1'b1;
            FRAME_CRC   <= crc_next;
            LINE_COUNT  <= vline_inc;
            FRAME_ERR   <= (vline_inc != v_total);
            crc_q       <= crc_init;
          end
        end
        default: state_q <= st_idle;
      endcase
    end
  end

`ifdef VGA_SIG_PIXCNT_EN
  logic [18:0] pix_q, pix_next;

  // Count of non-zero sampled pixels, saturating.
  always_comb begin
    pix_next = pix_q;
    if (sample && (RGB != 8'd0) && (pix_q != 19'h7FFFF)) pix_next = pix_q + 19'd1;
  end

  // Per-frame non-zero pixel count, latched alongside FRAME_VALID.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pix_q       <= '0;
      PIX_NONZERO <= '0;
    end else if (state_q == st_sync) begin
      if (vfall) pix_q <= '0;
    end else if (state_q == st_measure) begin
      if (vfall) begin
        PIX_NONZERO <= pix_next;
        pix_q       <= '0;
      end else begin
        pix_q <= pix_next;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vga_frame_signature.sv
// Directed bench for vga_frame_signature using small timing (20-cycle lines,
// 10-line frames). A second instance with CLK_PER_PIX=2 shares the sync
// stimulus to exercise the pixel phase counter. Expected CRCs come from a
// byte-wise software CRC-16-CCITT model of the active-region pixel stream.
module tb_vga_frame_signature;

  logic       HCLK = 1'b0;
  logic       HRESETn = 1'b0;
  logic       HSYNC = 1'b1;
  logic       VSYNC = 1'b1;
  logic [7:0] RGB = 8'd0;

  logic        fv1, lerr1, ferr1, lock1;
  logic [15:0] crc1;
  logic [11:0] lp1, hw1;
  logic [10:0] lc1;
  logic        fv2, lerr2, ferr2, lock2;
  logic [15:0] crc2;
  logic [11:0] lp2, hw2;
  logic [10:0] lc2;
`ifdef VGA_SIG_PIXCNT_EN
  logic [18:0] pix1, pix2;
`endif

  int checks = 0;
  int errors = 0;
  int fv_cnt1 = 0, fv_cnt2 = 0, fv_prev = 0;
  logic [15:0] cap_crc1, cap_crc2;
  logic [10:0] cap_lc;
  logic        cap_ferr;
  logic [11:0] cap_lp, cap_hw;
  logic [18:0] cap_pix;
  logic [15:0] crc_zero, crc_pat1, crc_mod1, crc_pat2, crc_mod2;

  always #5 HCLK = ~HCLK;

  vga_frame_signature #(
    .CLK_PER_PIX(1), .H_TOTAL(20), .H_START(4), .H_ACTIVE(8),
    .V_TOTAL(10), .V_START(2), .V_ACTIVE(4)
  ) dut1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB),
    .FRAME_VALID(fv1), .FRAME_CRC(crc1), .LINE_PERIOD(lp1), .HSYNC_WIDTH(hw1),
    .LINE_COUNT(lc1), .LINE_ERR(lerr1), .FRAME_ERR(ferr1), .LOCKED(lock1)
`ifdef VGA_SIG_PIXCNT_EN
    , .PIX_NONZERO(pix1)
`endif
  );

  vga_frame_signature #(
    .CLK_PER_PIX(2), .H_TOTAL(20), .H_START(2), .H_ACTIVE(8),
    .V_TOTAL(10), .V_START(2), .V_ACTIVE(4)
  ) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB),
    .FRAME_VALID(fv2), .FRAME_CRC(crc2), .LINE_PERIOD(lp2), .HSYNC_WIDTH(hw2),
    .LINE_COUNT(lc2), .LINE_ERR(lerr2), .FRAME_ERR(ferr2), .LOCKED(lock2)
`ifdef VGA_SIG_PIXCNT_EN
    , .PIX_NONZERO(pix2)
`endif
  );

  // Count FRAME_VALID cycles and snapshot the results presented with them.
  always @(negedge HCLK) begin
    if (fv1) begin
      fv_cnt1++;
      cap_crc1 = crc1;
      cap_lc   = lc1;
      cap_ferr = ferr1;
      cap_lp   = lp1;
      cap_hw   = hw1;
`ifdef VGA_SIG_PIXCNT_EN
      cap_pix  = pix1;
`endif
    end
    if (fv2) begin
      fv_cnt2++;
      cap_crc2 = crc2;
    end
  end

  // Software CRC-16-CCITT: byte XORed into the high byte, then 8 shifts.
  function automatic logic [15:0] sw_crc(input logic [15:0] c_in, input logic [7:0] b);
    logic [15:0] c;
    c = c_in ^ {b, 8'h00};
    repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    return c;
  endfunction

  // Expected frame CRC: active lines 2..5, samples at hstart + k*cpp, RGB = hcnt.
  function automatic logic [15:0] frame_crc(input int pattern, input int hs, input int cpp,
                                            input int mod_line, input int mod_h);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int v = 2; v < 6; v++) begin
      for (int k = 0; k < 8; k++) begin
        b = pattern ? 8'(hs + k * cpp) : 8'd0;
        if (v == mod_line && (hs + k * cpp) == mod_h) b = b ^ 8'h80;
        c = sw_crc(c, b);
      end
    end
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
    checks++;
    assert (obs !== bad) else begin
      errors++;
      $error("FAIL %s: observed %0h expected anything but %0h", tag, obs, bad);
    end
  endtask

  // One line: HSYNC low for cycles 0-1; in pattern mode RGB follows the DUT hcnt (c-1).
  task automatic do_line(input int len, input bit vs_low, input bit pattern, input bit modify);
    for (int c = 0; c < len; c++) begin
      @(negedge HCLK);
      HSYNC = (c < 2) ? 1'b0 : 1'b1;
      VSYNC = vs_low ? 1'b0 : 1'b1;
      RGB   = (pattern && c >= 1) ? 8'(c - 1) : 8'd0;
      if (modify && c == 7) RGB = RGB ^ 8'h80;
    end
  endtask

  task automatic run_frame(input int nlines, input bit pattern, input int mod_line);
    for (int l = 0; l < nlines; l++) do_line(20, l == 0, pattern, l == mod_line);
  endtask

  task automatic check_fv(input string tag, input int exp);
    check(tag, 32'(fv_cnt1 - fv_prev), 32'(exp));
    fv_prev = fv_cnt1;
  endtask

  initial begin
    crc_zero = frame_crc(0, 4, 1, -1, -1);
    crc_pat1 = frame_crc(1, 4, 1, -1, -1);
    crc_mod1 = frame_crc(1, 4, 1, 3, 6);
    crc_pat2 = frame_crc(1, 2, 2, -1, -1);
    crc_mod2 = frame_crc(1, 2, 2, 3, 6);

    // Reset state
    repeat (3) @(negedge HCLK);
    check("rst_fv",    32'(fv1), 0);
    check("rst_crc",   32'(crc1), 0);
    check("rst_lp",    32'(lp1), 0);
    check("rst_hw",    32'(hw1), 0);
    check("rst_lc",    32'(lc1), 0);
    check("rst_lerr",  32'(lerr1), 0);
    check("rst_ferr",  32'(ferr1), 0);
    check("rst_lock",  32'(lock1), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    do_line(20, 0, 0, 0);
    do_line(20, 0, 0, 0);

    // Two VSYNC falls before any FRAME_VALID
    run_frame(10, 0, -1);
    check_fv("f0_fv", 0);
    check("f0_lock", 32'(lock1), 0);
    run_frame(10, 0, -1);
    check_fv("f1_fv", 0);
    check("f1_lock", 32'(lock1), 1);

    // All-zero frames
    run_frame(10, 0, -1);
    check_fv("f2_fv", 1);
    check("f2_crc",  32'(cap_crc1), 32'(crc_zero));
    check("f2_lc",   32'(cap_lc), 10);
    check("f2_ferr", 32'(cap_ferr), 0);
    check("f2_lp",   32'(cap_lp), 20);
    check("f2_hw",   32'(cap_hw), 2);
    check("f2_lerr", 32'(lerr1), 0);
    check("f2_crc2", 32'(cap_crc2), 32'(crc_zero));
    check("f2_fv2",  32'(fv_cnt2), 1);
`ifdef VGA_SIG_PIXCNT_EN
    check("f2_pix",  32'(cap_pix), 0);
`endif
    run_frame(10, 0, -1);
    check_fv("f3_fv", 1);
    check("f3_crc", 32'(cap_crc1), 32'(crc_zero));

    // Pattern frames: RGB = hcnt
    run_frame(10, 1, -1);
    check_fv("f4_fv", 1);
    check("f4_crc", 32'(cap_crc1), 32'(crc_zero));
    run_frame(10, 1, -1);
    check_fv("f5_fv", 1);
    check("f5_crc",  32'(cap_crc1), 32'(crc_pat1));
    check("f5_crc2", 32'(cap_crc2), 32'(crc_pat2));
`ifdef VGA_SIG_PIXCNT_EN
    check("f5_pix",  32'(cap_pix), 32);
`endif
    run_frame(10, 1, 3);
    check_fv("f6_fv", 1);
    check("f6_crc", 32'(cap_crc1), 32'(crc_pat1));

    // Stretched line 4 in this frame; closes the single-pixel-modified frame
    do_line(20, 1, 1, 0);
    check_fv("f7_fv", 1);
    check("f7_crc_mod",  32'(cap_crc1), 32'(crc_mod1));
    check_ne("f7_crc_chg", 32'(cap_crc1), 32'(crc_pat1));
    check("f7_crc2_mod", 32'(cap_crc2), 32'(crc_mod2));
    for (int l = 1; l < 4; l++) do_line(20, 0, 1, 0);
    check("f7_lerr_pre", 32'(lerr1), 0);
    do_line(23, 0, 1, 0);
    do_line(20, 0, 1, 0);
    check("f7_lp23",  32'(lp1), 23);
    check("f7_lerr",  32'(lerr1), 1);
    check("f7_lerr2", 32'(lerr2), 1);
    for (int l = 6; l < 10; l++) do_line(20, 0, 1, 0);

    run_frame(10, 1, -1);
    check_fv("f8_fv", 1);
    check("f8_crc",  32'(cap_crc1), 32'(crc_pat1));
    check("f8_lp",   32'(cap_lp), 20);
    check("f8_ferr", 32'(cap_ferr), 0);
    check("f8_lerr", 32'(lerr1), 1);

    // 11-line frame
    run_frame(11, 1, -1);
    check_fv("f9_fv", 1);
    run_frame(10, 1, -1);
    check_fv("f10_fv", 1);
    check("f10_lc",   32'(cap_lc), 11);
    check("f10_ferr", 32'(cap_ferr), 1);
    check("f10_crc",  32'(cap_crc1), 32'(crc_pat1));
    run_frame(10, 1, -1);
    check_fv("f11_fv", 1);
    check("f11_lc",   32'(cap_lc), 10);
    check("f11_ferr", 32'(cap_ferr), 0);
    check("f11_lerr", 32'(lerr1), 1);

    // Reset mid-frame
    do_line(20, 1, 1, 0);
    do_line(20, 0, 1, 0);
    do_line(20, 0, 1, 0);
    check_fv("f12_fv", 1);
    HRESETn = 1'b0;
    #1;
    check("mid_crc",   32'(crc1), 0);
    check("mid_lc",    32'(lc1), 0);
    check("mid_lp",    32'(lp1), 0);
    check("mid_hw",    32'(hw1), 0);
    check("mid_lerr",  32'(lerr1), 0);
    check("mid_ferr",  32'(ferr1), 0);
    check("mid_lock",  32'(lock1), 0);
    check("mid_lerr2", 32'(lerr2), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int l = 3; l < 10; l++) do_line(20, 0, 1, 0);
    fv_prev = fv_cnt1;

    run_frame(10, 0, -1);
    check_fv("f13_fv", 0);
    check("f13_lock", 32'(lock1), 0);
    run_frame(10, 0, -1);
    check_fv("f14_fv", 0);
    check("f14_lock", 32'(lock1), 1);
    run_frame(10, 1, -1);
    check_fv("f15_fv", 1);
    check("f15_crc",  32'(cap_crc1), 32'(crc_zero));
    check("f15_lc",   32'(cap_lc), 10);
    check("f15_lerr", 32'(lerr1), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
